// File: rtl/sentinel_attempt_guard.sv
// Key/commit conditioning and attempt-guard FSM for the Sentinel lock front-end.
// Counts consecutive bad keys and imposes a timed lockout after too many failures.

module sentinel_debounce #(
    parameter int WIDTH         = 1,
    parameter int STABLE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] deb
);
    localparam int CW = $clog2(STABLE_CYCLES);

    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;
    logic [WIDTH-1:0] cand_reg;
    logic [WIDTH-1:0] deb_reg;
    logic [CW-1:0]    cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            cand_reg  <= '0;
            deb_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            if (sync2_reg != cand_reg) begin
                cand_reg <= sync2_reg;
                cnt_reg  <= '0;
            end else if (cnt_reg == CW'(STABLE_CYCLES - 1)) begin
                deb_reg <= cand_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign deb = deb_reg;
endmodule

module sentinel_attempt_guard #(
    parameter logic [7:0] KEY            = 8'hB6,
    parameter int         STABLE_CYCLES  = 16,
    parameter int         MAX_FAILS      = 3,
    parameter int         LOCKOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] sw_in,
    input  logic       commit_in,
    output logic [7:0] key_stable,
    output logic       auth_ok,
    output logic       locked_out,
    output logic [2:0] fail_count,
    output logic [1:0] state_code
);
    localparam int TW = $clog2(LOCKOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EVAL    = 2'd1,
        GRANTED = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    logic [7:0]    key_deb;
    logic          commit_deb;
    logic          commit_deb_d_reg;
    logic          commit_event;
    state_t        state_reg, state_next;
    logic [2:0]    fail_count_reg, fail_count_next;
    logic [2:0]    fail_inc;
    logic [TW-1:0] timer_reg, timer_next;

    sentinel_debounce #(.WIDTH(8), .STABLE_CYCLES(STABLE_CYCLES)) u_key_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (sw_in),
        .deb   (key_deb)
    );

    sentinel_debounce #(.WIDTH(1), .STABLE_CYCLES(STABLE_CYCLES)) u_commit_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (commit_in),
        .deb   (commit_deb)
    );

    // Rising edge of the debounced button: one event per press, however long it is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_deb_d_reg <= 1'b0;
        end else begin
            commit_deb_d_reg <= commit_deb;
        end
    end

    assign commit_event = commit_deb & ~commit_deb_d_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            fail_count_reg <= '0;
            timer_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            fail_count_reg <= fail_count_next;
            timer_reg      <= timer_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        fail_count_next = fail_count_reg;
        timer_next      = timer_reg;
        fail_inc        = fail_count_reg + 3'd1;
        if (ena) begin
            case (state_reg)
                IDLE: begin
                    if (commit_event) begin
                        state_next = EVAL;
                    end
                end
                EVAL: begin
                    if (key_deb == KEY) begin
                        state_next      = GRANTED;
                        fail_count_next = '0;
                    end else begin
                        fail_count_next = fail_inc;
                        if (fail_inc == 3'(MAX_FAILS)) begin
                            state_next = LOCKOUT;
                            timer_next = TW'(LOCKOUT_CYCLES - 1);
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                GRANTED: begin
                    if (key_deb != KEY) begin
                        state_next = IDLE;
                    end
                end
                LOCKOUT: begin
                    // The load value is one less than the duration, so zero is the last locked cycle.
                    if (timer_reg == '0) begin
                        state_next      = IDLE;
                        fail_count_next = '0;
                    end else begin
                        timer_next = timer_reg - 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign key_stable = key_deb;
    assign auth_ok    = (state_reg == GRANTED);
    assign locked_out = (state_reg == LOCKOUT);
    assign fail_count = fail_count_reg;
    assign state_code = state_reg;
endmodule

// File: doc/sentinel_attempt_guard.md
Name: sentinel_attempt_guard

Overview:
Upstream front-end for the Sentinel lock. It conditions the raw DIP-switch key and the commit push-button, then evaluates each committed key against the hardcoded Vaelix key. Consecutive failed attempts are counted, and after too many failures the gate enters a timed lockout. Its outputs (auth_ok, locked_out, fail_count) drive the display and the glow-status stage downstream.

Parameters:
KEY, 8'hB6, authorization key compared on each commit.
STABLE_CYCLES, 16, consecutive identical synchronized samples required before a debounced value updates (>=2).
MAX_FAILS, 3, consecutive failed commits that trigger lockout (1..7).
LOCKOUT_CYCLES, 1024, lockout duration in clk cycles (>=2).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  power-state enable; low freezes FSM and lockout timer
sw_in  in  8  raw DIP-switch key, asynchronous
commit_in  in  1  raw commit button, asynchronous, active high
key_stable  out  8  debounced key
auth_ok  out  1  high while in GRANTED
locked_out  out  1  high while in LOCKOUT
fail_count  out  3  consecutive failed attempts
state_code  out  2  IDLE=0, EVAL=1, GRANTED=2, LOCKOUT=3

Behaviour:
- Reset (async assert, sync release): all flops cleared. key_stable=8'h00, auth_ok=0, locked_out=0, fail_count=0, state_code=0, lockout timer=0, debounce counters=0.
- Synchronizers: sw_in and commit_in each pass through 2 flops. These run regardless of ena.
- Debouncer (separate instance for the 8-bit key and for commit), evaluated each cycle:
  - If synced value != candidate: candidate<=synced, cnt<=0.
  - Else if cnt==STABLE_CYCLES-1: debounced<=candidate.
  - Else: cnt++ (saturating).
  - Timing: if edge 0 first samples a new raw value, the debounced output changes at edge STABLE_CYCLES+2.
  - A bounce shorter than STABLE_CYCLES synced cycles never reaches the debounced output.
- Commit event: one-cycle pulse = commit_deb & ~commit_deb_d. A held button produces exactly one event.
- FSM (advances only when ena=1; when ena=0 all state, counters and timer hold and events are dropped):
  - IDLE: on commit event -> EVAL.
  - EVAL (1 cycle): compare key_stable with KEY.
    - Match -> GRANTED, fail_count<=0.
    - Mismatch -> fail_count+1. If the new count equals MAX_FAILS -> LOCKOUT and load timer with LOCKOUT_CYCLES-1. Otherwise -> IDLE.
  - GRANTED: auth_ok=1. Exit to IDLE on the first cycle key_stable != KEY. Commit events are ignored.
  - LOCKOUT: locked_out=1 and commit events are ignored.
    - Timer decrements each enabled cycle.
    - When the timer is 0: -> IDLE, fail_count<=0.
    - With ena held high, LOCKOUT lasts exactly LOCKOUT_CYCLES cycles.
- Latency: commit sampled high at edge 0 (key already stable) -> EVAL at edge STABLE_CYCLES+3 -> GRANTED/IDLE/LOCKOUT at edge STABLE_CYCLES+4.
- Simultaneous events:
  - A key change that lands in the same cycle as EVAL: EVAL uses the registered key_stable value of that cycle.
  - A commit event that coincides with the GRANTED->IDLE exit is dropped.
- fail_count saturates at MAX_FAILS. It is never nonzero after a successful grant.
- Reset during LOCKOUT or GRANTED returns immediately to IDLE with all outputs at reset values.
- Outputs are registered or decoded from state flops only; there is no combinational path from sw_in or commit_in to any output.

Test Plan:
(Sim params: STABLE_CYCLES=4, MAX_FAILS=3, LOCKOUT_CYCLES=32.)
1. Reset and correct key: assert rst_n=0 mid-run, then release. Set sw_in=8'hB6, wait 10 cycles, pulse commit_in high for 8 cycles. Required: key_stable=8'hB6; state_code=2 and auth_ok=1 at exactly edge 8 after commit is first sampled; fail_count=0.
2. Grant release: from GRANTED, change sw_in to 8'hB7. Required: auth_ok falls and state_code=0 at edge 7 after the change.
3. Bounce rejection: toggle commit_in every 2 cycles for 20 cycles, then hold low. Required: no commit event, state_code stays 0. Repeat with sw_in glitches of 3 cycles: key_stable is unchanged.
4. Lockout entry: sw_in=8'h00, commit 3 times. Required: fail_count reads 1, then 2; the third commit gives locked_out=1, state_code=3. A commit with 8'hB6 during lockout is ignored (auth_ok stays 0).
5. Lockout expiry: from LOCKOUT entry, wait exactly 32 cycles. Required: locked_out=0, state_code=0, fail_count=0 at cycle 32 and not at cycle 31. Then a commit of 8'hB6 is granted.
6. Enable freeze and reset mid-lockout:
   - Drop ena for 50 cycles mid-lockout. Required: timer holds and lockout ends 50 cycles later than in scenario 5.
   - Assert rst_n=0 mid-lockout. Required: all outputs return to reset values immediately.
